// File: rtl/cpu_pkg.sv
// Shared CPU package: default register-file geometry and the encoding of
// the post-reset clear-sweep FSM states.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Number of architectural registers addressed by an index of width aw.
  function automatic int num_regs(input int aw);
    return 1 << aw;
  endfunction

  localparam int NUM_REGS = num_regs(ADDR_W_DEF);

  // CLEAR: sweeping zeros into the array after reset; IDLE: normal operation.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_t;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sweep for the register file.
// Reset parks the FSM in CLEAR with the counter at 1 (register 0 is
// hardwired, so it never needs clearing). Each CLEAR cycle zeroes one
// register and advances the counter; the cycle that clears the last
// index returns to IDLE, giving a busy window of 2**ADDR_W-1 cycles.
module regfile_clear_fsm
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic              busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_idx
);

  clr_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;

  // State and counter registers; reset restarts the sweep from index 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= CLEAR;
      cnt_reg   <= ADDR_W'(1);
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and sweep outputs; no clearing happens in a reset cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    busy       = 1'b0;
    clr_en     = 1'b0;
    clr_idx    = cnt_reg;
    case (state_reg)
      CLEAR: begin
        busy     = 1'b1;
        clr_en   = ~reset;
        cnt_next = cnt_reg + ADDR_W'(1);
        if (cnt_reg == {ADDR_W{1'b1}}) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file with register 0 hardwired to zero.
// After reset a sweep (regfile_clear_fsm) zeroes every register; while it
// runs, busy is high, writes are dropped and both read ports return 0.
// Optional feature macro: REG_FILE_BYPASS_EN -- when defined, a write in
// progress is forwarded to any read port addressing the same register.
module reg_file
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy
);

  localparam int NREGS = num_regs(ADDR_W);

  logic [DATA_W-1:0] regs [NREGS];
  logic              clr_en;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_en;

  logic [ADDR_W-1:0] raddr_arr [2];
  logic [DATA_W-1:0] rdata_arr [2];

  regfile_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk     (clk),
    .reset   (reset),
    .busy    (busy),
    .clr_en  (clr_en),
    .clr_idx (clr_idx)
  );

  assign wr_en = we & ~busy & ~reset & (waddr != '0);

  // Array update: the sweep and ordinary writes never overlap (writes need !busy).
  always_ff @(posedge clk) begin
    if (clr_en) begin
      regs[clr_idx] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  assign raddr_arr[0] = raddr1;
  assign raddr_arr[1] = raddr2;

  // Identical combinational read path for each port.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [DATA_W-1:0] stored;
    logic              hit;
    logic              zero;

    assign stored = regs[raddr_arr[gi]];
    assign zero   = busy | (raddr_arr[gi] == '0);
`ifdef REG_FILE_BYPASS_EN
    assign hit = we & ~busy & (waddr == raddr_arr[gi]);
`else
    assign hit = 1'b0;
`endif
    assign rdata_arr[gi] = zero ? '0 : (hit ? wdata : stored);
  end

  assign rdata1 = rdata_arr[0];
  assign rdata2 = rdata_arr[1];

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file. Expectations are queued when
// a step is driven and popped/compared mid-cycle on the falling edge.
module tb_reg_file;
  import cpu_pkg::*;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        bz;
  } exp_t;

  exp_t sb[$];

  reg_file #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle: drive inputs, queue the expectation, compare at negedge.
  task automatic step(input logic rst, input logic w, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] a1,
                      input logic [4:0] a2, input logic [31:0] e1,
                      input logic [31:0] e2, input logic eb, input string tag);
    exp_t e;
    exp_t got;
    reset  = rst;
    we     = w;
    waddr  = wa;
    wdata  = wd;
    raddr1 = a1;
    raddr2 = a2;
    e.tag = tag;
    e.r1  = e1;
    e.r2  = e2;
    e.bz  = eb;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    checks++;
    assert (busy === got.bz) else begin
      errors++;
      $error("FAIL %s busy: observed=%b expected=%b", got.tag, busy, got.bz);
    end
    checks++;
    assert (rdata1 === got.r1) else begin
      errors++;
      $error("FAIL %s rdata1: observed=%h expected=%h", got.tag, rdata1, got.r1);
    end
    checks++;
    assert (rdata2 === got.r2) else begin
      errors++;
      $error("FAIL %s rdata2: observed=%h expected=%h", got.tag, rdata2, got.r2);
    end
    $display("step %-14s rst=%b we=%b wa=%0d wd=%h ra1=%0d ra2=%0d -> busy=%b rd1=%h rd2=%h",
             got.tag, rst, w, wa, wd, a1, a2, busy, rdata1, rdata2);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] byp_deadbeef;
  logic [31:0] byp_r3_first;
  logic [31:0] byp_r3_second;

  initial begin
`ifdef REG_FILE_BYPASS_EN
    byp_deadbeef  = 32'hDEAD_BEEF;
    byp_r3_first  = 32'h0000_0001;
    byp_r3_second = 32'h0000_0002;
`else
    byp_deadbeef  = 32'h0000_0000;
    byp_r3_first  = 32'h0000_0000;
    byp_r3_second = 32'h0000_0001;
`endif
    // Initial reset: one cycle, state before it is undefined so not checked.
    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    @(posedge clk);
    #1;

    // Sweep: 31 busy cycles; writes to r7 late in the sweep must be dropped.
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      step(1'b0, (i >= 20), 5'd7, 32'h1234_5678, 5'(i), 5'(30 - i),
           32'h0, 32'h0, 1'b1, "sweep_busy");
    end
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd1, 32'h0, 32'h0, 1'b0, "busy_drop");
    for (int i = 0; i < NUM_REGS; i++) begin
      step(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(NUM_REGS - 1 - i),
           32'h0, 32'h0, 1'b0, "all_zero");
    end

    // Basic write then read.
    step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, byp_deadbeef, 32'h0, 1'b0, "wr_r5");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0, 1'b0, "rd_r5");

    // Register 0 is hardwired.
    step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, "wr_r0");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 32'h0, 32'hDEAD_BEEF, 1'b0, "rd_r0");

    // Same-cycle read of a register being written.
    step(1'b0, 1'b1, 5'd3, 32'h0000_0001, 5'd3, 5'd5, byp_r3_first, 32'hDEAD_BEEF, 1'b0, "wr_r3_1");
    step(1'b0, 1'b1, 5'd3, 32'h0000_0002, 5'd3, 5'd3, byp_r3_second, byp_r3_second, 1'b0, "wr_r3_2");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 32'h0000_0002, 32'h0000_0002, 1'b0, "rd_r3");

    // Top and bottom indices, independent ports.
    step(1'b0, 1'b1, 5'd31, 32'hA5A5_A5A5, 5'd5, 5'd3, 32'hDEAD_BEEF, 32'h2, 1'b0, "wr_r31");
    step(1'b0, 1'b1, 5'd1, 32'h0000_0001, 5'd31, 5'd7, 32'hA5A5_A5A5, 32'h0, 1'b0, "wr_r1");
    step(1'b0, 1'b1, 5'd9, 32'hCAFE_F00D, 5'd1, 5'd31, 32'h1, 32'hA5A5_A5A5, 1'b0, "wr_r9");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, "rd_r9");

    // Reset from IDLE: the reset cycle itself clears nothing and commits nothing.
    step(1'b1, 1'b1, 5'd12, 32'h5555_5555, 5'd9, 5'd5, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0, "rst_cycle");
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd5, 32'h0, 32'h0, 1'b1, "sweep2_busy");
    end
    // Reset mid-sweep restarts the full window.
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd5, 32'h0, 32'h0, 1'b1, "midsweep_rst");
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      step(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd31, 32'h0, 32'h0, 1'b1, "sweep3_busy");
    end
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd5, 32'h0, 32'h0, 1'b0, "r9_cleared");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd3, 32'h0, 32'h0, 1'b0, "r31_cleared");

    // Write works again after the second sweep.
    step(1'b0, 1'b1, 5'd12, 32'h0BAD_F00D, 5'd12, 5'd0,
`ifdef REG_FILE_BYPASS_EN
         32'h0BAD_F00D,
`else
         32'h0,
`endif
         32'h0, 1'b0, "wr_r12");
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 5'd12, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, "rd_r12");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register and port data width.
REQ-002 SHALL have parameter ADDR_W, default 5: register index width (2**ADDR_W registers).
REQ-003 SHALL have port clk, input, 1: sole clock, rising-edge active.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port we, input, 1: write enable.
REQ-006 SHALL have port waddr, input, ADDR_W: write register index.
REQ-007 SHALL have port wdata, input, DATA_W: write data.
REQ-008 SHALL have port raddr1, input, ADDR_W: read port 1 index.
REQ-009 SHALL have port raddr2, input, ADDR_W: read port 2 index.
REQ-010 SHALL have port rdata1, output, DATA_W: read port 1 data, feeds ALU operand a and the downstream 32-bit select mux.
REQ-011 SHALL have port rdata2, output, DATA_W: read port 2 data, feeds the ALU-source select mux.
REQ-012 SHALL have port busy, output, 1: post-reset clear sweep in progress.

Function
REQ-013 SHALL implement reads as combinational: rdataN = reg[raddrN] in the same cycle.
REQ-014 SHALL hardwire register 0: reads of index 0 return 0, and writes to index 0 are discarded.
REQ-015 SHALL commit a write at the rising edge when we=1, busy=0, reset=0 and waddr!=0.
REQ-016 SHALL force rdata1 and rdata2 to 0 while busy=1.
REQ-017 SHALL use a two-state FSM, CLEAR and IDLE, plus a clear counter cnt of width ADDR_W.
REQ-018 SHALL perform in CLEAR, each cycle: reg[cnt] <= 0, cnt <= cnt+1, busy=1.
REQ-019 SHALL transition CLEAR to IDLE on the edge where cnt == 2**ADDR_W-1 is cleared; cnt wraps to 0 and is unused in IDLE.
REQ-020 SHALL hold busy=1 for exactly 2**ADDR_W-1 cycles (31 at default) after reset deasserts, then busy=0.
REQ-021 SHALL ignore we while busy=1, with no deferred or queued write.
REQ-022 SHALL apply simultaneous reads of the same index on both ports independently, returning identical data.

Reset
REQ-023 SHALL, on any edge with reset=1: state <= CLEAR, cnt <= 1, busy=1, and rdata1=rdata2=0 from the next cycle.
REQ-024 SHALL restart the sweep at cnt=1 when reset is asserted mid-sweep, with the full 31-cycle busy window repeated.
REQ-025 SHALL NOT clear the register array in the reset cycle itself; clearing occurs only via the sweep.
REQ-026 SHALL NOT commit any write in a cycle where reset=1.

Configuration
REQ-027 SHALL, with macro REG_FILE_BYPASS_EN defined, forward write data to the read ports: when we=1, busy=0 and waddr==raddrN!=0, rdataN = wdata in the same cycle.
REQ-028 SHALL, without REG_FILE_BYPASS_EN, return the pre-write stored value in the write cycle; new data is visible from the next cycle.

Structure
REQ-029 SHALL take DATA_W/ADDR_W defaults, the NUM_REGS constant and the FSM state encoding (CLEAR, IDLE) from the shared package cpu_pkg.
REQ-030 SHALL place the FSM and counter in one sub-module, regfile_clear_fsm (outputs busy, clr_en, clr_idx); the array and read logic stay in reg_file.

Verification
REQ-031 SHALL cover: reset 1 cycle, then release -> busy=1 for 31 cycles, busy=0 on the 32nd; all registers read 0.
REQ-032 SHALL cover: after the sweep, write r5=0xDEADBEEF, then read raddr1=5 next cycle -> rdata1=0xDEADBEEF; with raddr2=0 -> rdata2=0.
REQ-033 SHALL cover: write r0=0xFFFFFFFF -> raddr1=0 yields 0.
REQ-034 SHALL cover: we=1, waddr=7, wdata=0x12345678 during busy -> after the sweep r7 reads 0.
REQ-035 SHALL cover: r3=0x1 stored; in the same cycle write r3=0x2 with raddr1=3 -> rdata1=0x2 with REG_FILE_BYPASS_EN, 0x1 without; 0x2 the next cycle in both builds.
REQ-036 SHALL cover: reset pulsed at sweep cycle 10 -> busy stays 1 for a further 31 cycles after release; r9 written before the first reset reads 0 afterwards.
